// File: rtl/cnu_minsum_serial_if.sv
// Stream bundle for the serial min-sum check node: q messages in, parallel r/parity out.
interface cnu_minsum_serial_if #(
    parameter int unsigned data_w = 8,
    parameter int unsigned D      = 6
);
    logic                  in_valid;
    logic                  in_ready;
    logic [data_w-1:0]     in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [data_w*D-1:0]   r;
    logic                  parity;

    // Producer/consumer side: drives q messages and consumes r/parity
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, r, parity
    );

    // Check node side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, r, parity
    );
endinterface

// File: rtl/cnu_minsum_serial.sv
// Offset min-sum check node unit: accumulates D serial q messages, tracks the two
// smallest magnitudes and the sign product, then emits all D r messages at once.
module cnu_minsum_serial #(
    parameter int unsigned data_w = 8,
    parameter int unsigned D      = 6,
    parameter int unsigned OFFSET = 1
) (
    input logic                 clk,
    input logic                 rst,
    cnu_minsum_serial_if.slave  bus
);
    localparam int unsigned idx_w = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned mag_w = data_w - 1;
    localparam logic [mag_w-1:0] mag_max  = {mag_w{1'b1}};
    localparam logic [mag_w-1:0] off_m    = mag_w'(OFFSET);
    localparam logic [idx_w-1:0] last_idx = idx_w'(D - 1);

    typedef enum logic {ACC, FULL} state_t;

    state_t state;
    state_t state_next;
    logic   load;
    logic   accept;

    logic [idx_w-1:0] cnt;
    logic [mag_w-1:0] min1;
    logic [mag_w-1:0] min2;
    logic [idx_w-1:0] idx1;
    logic             sprod;
    logic [D-1:0]     sgn_vec;

    logic             sgn;
    logic [mag_w-1:0] neg;
    logic [mag_w-1:0] mag;

    logic                 out_valid_q;
    logic [data_w*D-1:0]  r_q;
    logic                 parity_q;
    logic [data_w*D-1:0]  r_next;

    assign bus.in_ready  = (state == ACC) & ~rst;
    assign bus.out_valid = out_valid_q;
    assign bus.r         = r_q;
    assign bus.parity    = parity_q;
    assign accept        = bus.in_valid & bus.in_ready;

    // Sign/magnitude split of the incoming message; the most negative code saturates
    always_comb begin
        sgn = bus.in_data[data_w-1];
        neg = mag_w'(0) - bus.in_data[mag_w-1:0];
        mag = bus.in_data[mag_w-1:0];
        if (sgn) begin
            if (bus.in_data[mag_w-1:0] == '0) begin
                mag = mag_max;
            end else begin
                mag = neg;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    // Next state and output-load decision; FULL waits until the output slot frees up
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            ACC: begin
                if (accept && (cnt == last_idx)) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (!out_valid_q || bus.out_ready) begin
                    load       = 1'b1;
                    state_next = ACC;
                end
            end
            default: state_next = ACC;
        endcase
    end

    // Running two-minimum search, sign product and per-message sign capture
    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt     <= '0;
            min1    <= mag_max;
            min2    <= mag_max;
            idx1    <= '0;
            sprod   <= 1'b0;
            sgn_vec <= '0;
        end else if (accept) begin
            sgn_vec[cnt] <= sgn;
            sprod        <= sprod ^ sgn;
            cnt          <= cnt + idx_w'(1);
            if (mag < min1) begin
                min2 <= min1;
                min1 <= mag;
                idx1 <= cnt;
            end else if (mag < min2) begin
                min2 <= mag;
            end
        end
    end

    // Per-output magnitude selection, offset with floor at zero, and sign restore
    always_comb begin
        logic [mag_w-1:0]  m;
        logic [mag_w-1:0]  mp;
        logic [data_w-1:0] ext;
        logic              s;
        r_next = '0;
        m      = '0;
        mp     = '0;
        ext    = '0;
        s      = 1'b0;
        for (int i = 0; i < int'(D); i++) begin
            m   = (idx_w'(i) == idx1) ? min2 : min1;
            mp  = (m > off_m) ? (m - off_m) : '0;
            s   = sprod ^ sgn_vec[i];
            ext = {1'b0, mp};
            r_next[i*data_w +: data_w] = s ? (data_w'(0) - ext) : ext;
        end
    end

    // Output register: loads a finished frame, holds under backpressure, drops valid on transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            r_q         <= '0;
            parity_q    <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            r_q         <= r_next;
            parity_q    <= sprod;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cnu_minsum_serial.sv
// Self-checking bench for cnu_minsum_serial: vector table, scoreboard and corner sequences.
module tb_cnu_minsum_serial;
    localparam int unsigned DW = 8;
    localparam int unsigned DD = 6;

    typedef logic [DD*DW-1:0] bus_t;
    typedef struct {
        bus_t q;
        bus_t r;
        logic parity;
    } vec_t;
    typedef struct {
        bus_t r;
        logic parity;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnu_minsum_serial_if #(.data_w(DW), .D(DD)) bus ();
    cnu_minsum_serial #(.data_w(DW), .D(DD), .OFFSET(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   xfer_t[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   nout  = 0;
    bit   rec_times = 1'b0;
    vec_t tab[3];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bus_t pack6(input int a0, input int a1, input int a2,
                                   input int a3, input int a4, input int a5);
        return {DW'(a5), DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    // Reference: each r_i is the minimum over the other messages, signed by the others' sign product
    function automatic exp_t model(input bus_t q);
        int   mag[DD];
        bit   sg[DD];
        exp_t e;
        int   best;
        int   mp;
        bit   s;
        logic signed [DW-1:0] x;
        e.parity = 1'b0;
        e.r      = '0;
        for (int j = 0; j < int'(DD); j++) begin
            x      = signed'(q[j*DW +: DW]);
            sg[j]  = x[DW-1];
            mag[j] = (x == -128) ? 127 : ((x < 0) ? -int'(x) : int'(x));
            e.parity ^= sg[j];
        end
        for (int i = 0; i < int'(DD); i++) begin
            best = 127;
            s    = 1'b0;
            for (int j = 0; j < int'(DD); j++) begin
                if (j != i) begin
                    if (mag[j] < best) best = mag[j];
                    s ^= sg[j];
                end
            end
            mp = (best > 1) ? best - 1 : 0;
            e.r[i*DW +: DW] = DW'(s ? -mp : mp);
        end
        return e;
    endfunction

    task automatic send_word(input logic [DW-1:0] x);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 50) begin
                check("in_ready_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bus_t q, input exp_t e, input bit drop);
        sb.push_back(e);
        for (int i = 0; i < int'(DD); i++) send_word(q[i*DW +: DW]);
        if (drop) bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0) begin
            @(posedge clk);
            n++;
            if (n > 100) begin
                check("drain_timeout", 64'(sb.size()), 64'd0);
                sb.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        exp_t ea;
        exp_t eb;
        bus_t qa;
        bus_t qb;
        bus_t qr;

        tab[0].q = pack6(5, -3, 7, 2, -9, 4);
        tab[0].r = pack6(1, -1, 1, 2, -1, 1);
        tab[0].parity = 1'b0;
        tab[1].q = pack6(-128, 10, 10, 10, 10, 10);
        tab[1].r = pack6(9, -9, -9, -9, -9, -9);
        tab[1].parity = 1'b1;
        tab[2].q = pack6(1, 0, 6, 6, 6, 6);
        tab[2].r = pack6(0, 0, 0, 0, 0, 0);
        tab[2].parity = 1'b0;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;

        // Output monitor: every transfer is matched against the scoreboard head
        fork
            forever begin
                @(negedge clk);
                if (!rst && bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", {15'd0, bus.parity, bus.r}, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("frame%0d", nout), {15'd0, bus.parity, bus.r},
                              {15'd0, e.parity, e.r});
                    end
                    nout++;
                    if (rec_times) xfer_t.push_back(cyc);
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_r", 64'(bus.r), 64'd0);
        check("rst_parity", 64'(bus.parity), 64'd0);
        check("rst_release_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed vector table; the first entry also checks the two-cycle latency
        for (int k = 0; k < 3; k++) begin
            send_frame(tab[k].q, '{r: tab[k].r, parity: tab[k].parity}, 1'b1);
            if (k == 0) begin
                @(negedge clk);
                check("latency_t1_low", 64'(bus.out_valid), 64'd0);
                @(negedge clk);
                check("latency_t2_high", 64'(bus.out_valid), 64'd1);
            end
            wait_drain();
        end

        // Backpressure: two frames queued, first held, one-cycle pulse swaps to the second
        qa = pack6(20, -30, 15, 40, -25, 18);
        qb = pack6(-7, 3, -11, 50, 6, -2);
        ea = model(qa);
        eb = model(qb);
        bus.out_ready = 1'b0;
        send_frame(qa, ea, 1'b1);
        send_frame(qb, eb, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("hold_in_ready_%0d", c), 64'(bus.in_ready), 64'd0);
            check($sformatf("hold_valid_%0d", c), 64'(bus.out_valid), 64'd1);
            check($sformatf("hold_r_%0d", c), {15'd0, bus.parity, bus.r}, {15'd0, ea.parity, ea.r});
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check("swap_valid", 64'(bus.out_valid), 64'd1);
        check("swap_r", {15'd0, bus.parity, bus.r}, {15'd0, eb.parity, eb.r});
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_drain();

        // Reset mid-frame discards the partial frame and clears the held output
        send_word(DW'(5));
        send_word(DW'(-3));
        send_word(DW'(7));
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_r", 64'(bus.r), 64'd0);
        @(posedge clk);
        #1;
        send_frame(tab[0].q, '{r: tab[0].r, parity: tab[0].parity}, 1'b1);
        wait_drain();

        // Continuous streaming: one frame every D+1 cycles
        rec_times = 1'b1;
        xfer_t.delete();
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < int'(DD); i++) qr[i*DW +: DW] = DW'($urandom_range(0, 255));
            if (f == 0) qr[0 +: DW] = 8'h80;
            if (f == 1) qr[2*DW +: DW] = 8'h00;
            send_frame(qr, model(qr), 1'b0);
        end
        bus.in_valid = 1'b0;
        wait_drain();
        rec_times = 1'b0;
        check("stream_count", 64'(xfer_t.size()), 64'd5);
        for (int f = 1; f < xfer_t.size(); f++) begin
            check($sformatf("stream_period_%0d", f), 64'(xfer_t[f] - xfer_t[f-1]), 64'd7);
        end
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
